// File: rtl/encoded_counter.sv
// Up/down counter with clear/load and a registered encoded view (binary, Gray or one-hot)
// of the count, plus a one-cycle terminal-count pulse on wrap.
module encoded_counter #(
  parameter  int WIDTH = 3,
  parameter  int MODE  = 1,
  localparam int OUT_W = 2**WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic [OUT_W-1:0] code_out,
  output logic             tc
);

  typedef enum logic [1:0] {ENC_BIN, ENC_GRAY, ENC_ONEHOT} enc_e;

  // Unsupported MODE values fall back to plain binary.
  localparam enc_e ENC = (MODE == 1) ? ENC_GRAY :
                         (MODE == 2) ? ENC_ONEHOT : ENC_BIN;

  logic [WIDTH-1:0] count_q, count_d;
  logic [OUT_W-1:0] code_q, code_d;
  logic             tc_q, tc_d;

  function automatic logic [OUT_W-1:0] encode(input logic [WIDTH-1:0] c);
    logic [OUT_W-1:0] r;
    r = '0;
    case (ENC)
      ENC_GRAY:   r[WIDTH-1:0] = c ^ (c >> 1);
      ENC_ONEHOT: r[c] = 1'b1;
      default:    r[WIDTH-1:0] = c;
    endcase
    return r;
  endfunction

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (up_dn) begin
        count_d = count_q + 1'b1;
        tc_d    = (count_q == '1);
      end else begin
        count_d = count_q - 1'b1;
        tc_d    = (count_q == '0);
      end
    end
    // Encoding the next count keeps code_out aligned with count on the same edge.
    code_d = encode(count_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      code_q  <= encode('0);
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      code_q  <= code_d;
      tc_q    <= tc_d;
    end
  end

  assign count    = count_q;
  assign code_out = code_q;
  assign tc       = tc_q;

endmodule

// File: tb/tb_encoded_counter.sv
// Randomized scoreboard bench for encoded_counter across several WIDTH/MODE instances
// sharing one stimulus stream.
module tb_encoded_counter;

  localparam int NI = 8;

  typedef struct {
    int         cnt;
    logic [63:0] code;
    bit         tc;
    bit         hd1;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       clr, load, en, up_dn;
  logic [5:0] lv;
  int         kind;
  event       issued;
  int         total;
  int         bad;

  function automatic int w_of(input int g);
    case (g)
      0: return 3; 1: return 3; 2: return 3; 3: return 4;
      4: return 2; 5: return 6; 6: return 5; default: return 4;
    endcase
  endfunction

  function automatic int m_of(input int g);
    case (g)
      0: return 1; 1: return 2; 2: return 0; 3: return 0;
      4: return 1; 5: return 2; 6: return 1; default: return 3;
    endcase
  endfunction

  function automatic logic [63:0] enc(input int w, input int m, input int c);
    logic [63:0] r;
    logic [63:0] cb;
    r  = '0;
    cb = 64'(c);
    if (m == 2) begin
      r = 64'd1 << c;
    end else if (m == 1) begin
      for (int i = 0; i < w; i++)
        r[i] = (i == w - 1) ? cb[i] : (cb[i+1] ^ cb[i]);
    end else begin
      r = cb;
    end
    return r;
  endfunction

  task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL inst%0d(W=%0d,M=%0d) %s actual=%0h required=%0h t=%0t",
               g, w_of(g), m_of(g), nm, act, req, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : u
    localparam int W  = w_of(g);
    localparam int M  = m_of(g);
    localparam int OW = 1 << W;

    logic [W-1:0]  cnt_w;
    logic [OW-1:0] code_w;
    logic          tc_w;

    encoded_counter #(.WIDTH(W), .MODE(M)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (load),
      .load_val (lv[W-1:0]),
      .en       (en),
      .up_dn    (up_dn),
      .count    (cnt_w),
      .code_out (code_w),
      .tc       (tc_w)
    );

    exp_t        q[$];
    int          mc;
    bit          have_prev;
    logic [63:0] prev;

    // Reference model: advances on each issued stimulus and queues the expected result.
    always @(issued) begin : model
      exp_t        e;
      int          n;
      logic [63:0] a;
      n = 1 << W;
      if (kind == 1) begin
        a = '0;
        a[OW-1:0] = code_w;
        chk(g, "rst_count", 64'(cnt_w), 64'd0);
        chk(g, "rst_code", a, enc(W, M, 0));
        chk(g, "rst_tc", 64'(tc_w), 64'd0);
        mc = 0;
        have_prev = 1'b0;
        q.delete();
      end else if (kind == 2) begin
        chk(g, "drain", 64'(q.size()), 64'd0);
      end else begin
        e.tc  = 1'b0;
        e.hd1 = 1'b0;
        if (clr) begin
          mc = 0;
        end else if (load) begin
          mc = int'(lv) % n;
        end else if (en) begin
          e.hd1 = (M == 1) && have_prev;
          if (up_dn) begin
            e.tc = (mc == n - 1);
            mc   = (mc + 1) % n;
          end else begin
            e.tc = (mc == 0);
            mc   = (mc + n - 1) % n;
          end
        end
        e.cnt  = mc;
        e.code = enc(W, M, mc);
        have_prev = 1'b1;
        q.push_back(e);
      end
    end

    always @(posedge clk) begin : monitor
      exp_t        e;
      logic [63:0] a;
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '0;
        a[OW-1:0] = code_w;
        chk(g, "count", 64'(cnt_w), 64'(e.cnt));
        chk(g, "code_out", a, e.code);
        chk(g, "tc", 64'(tc_w), 64'(e.tc));
        if (e.hd1)
          chk(g, "gray_hamming", 64'($countones(a ^ prev)), 64'd1);
        prev = a;
      end
    end
  end

  task automatic step(input bit c, input bit l, input int v, input bit e, input bit ud);
    @(negedge clk);
    clr   = c;
    load  = l;
    lv    = 6'(v);
    en    = e;
    up_dn = ud;
    kind  = 0;
    -> issued;
  endtask

  // Reset lands between edges; the check runs before any further clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    load  = 1'b0;
    #1;
    kind = 1;
    -> issued;
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    load  = 1'b0;
    en    = 1'b0;
    up_dn = 1'b1;
    lv    = '0;
    kind  = 0;

    do_reset();
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 1);
    step(0, 1, 5, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    step(0, 1, 6, 0, 0);
    step(1, 1, 3, 1, 1);
    step(0, 1, 2, 1, 1);
    step(0, 1, 9, 1, 1);
    step(0, 0, 0, 1, 1);
    do_reset();
    step(0, 0, 0, 1, 1);
    step(0, 1, 3, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 70; i++) step(0, 0, 0, 1, 1);
    for (int i = 0; i < 70; i++) step(0, 0, 0, 1, 0);

    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 31));
      step(r == 0, (r >= 1 && r <= 4), int'($urandom_range(0, 63)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
      if (i == 250) do_reset();
    end

    @(negedge clk);
    @(negedge clk);
    kind = 2;
    -> issued;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoded_counter.md
ENCODED_COUNTER -- requirements
Module: encoded_counter

Interface
REQ-001 Parameter: WIDTH, default 3, count register width in bits; legal range 2..6.
REQ-002 Parameter: MODE, default 1, output encoding; 0 = binary, 1 = Gray, 2 = one-hot.
REQ-003 Derived constant: OUT_W = 2**WIDTH, the width of code_out.
REQ-004 Port: clk, input, 1, the single clock; all state changes on the rising edge.
REQ-005 Port: rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 Port: clr, input, 1, synchronous clear of the count to 0.
REQ-007 Port: load, input, 1, synchronous load of load_val.
REQ-008 Port: load_val, input, WIDTH, value to load.
REQ-009 Port: en, input, 1, count enable.
REQ-010 Port: up_dn, input, 1, count direction; 1 = up, 0 = down.
REQ-011 Port: count, output, WIDTH, registered binary count.
REQ-012 Port: code_out, output, OUT_W, registered encoded form of count.
REQ-013 Port: tc, output, 1, registered terminal-count (wrap) pulse.

Function
REQ-014 Per-edge priority SHALL be clr > load > en > hold.
REQ-015 clr=1: count SHALL become 0 and tc SHALL be 0.
REQ-016 load=1 (clr=0): count SHALL become load_val and tc SHALL be 0, regardless of en.
REQ-017 en=1, up_dn=1: count SHALL increment modulo 2**WIDTH.
REQ-018 en=1, up_dn=0: count SHALL decrement modulo 2**WIDTH.
REQ-019 Up-count wrap (2**WIDTH-1 -> 0) or down-count wrap (0 -> 2**WIDTH-1) SHALL set tc=1 for exactly that cycle; tc SHALL be 0 on all other cycles.
REQ-020 en=0, no clr or load: count SHALL hold and tc SHALL be 0.
REQ-021 code_out SHALL be computed from the next-count value and registered on the same edge as count, so code_out always matches count with zero added latency.
REQ-022 MODE 0: code_out[WIDTH-1:0] = count; code_out[OUT_W-1:WIDTH] = 0.
REQ-023 MODE 1: code_out[WIDTH-1] = count[WIDTH-1]; code_out[i] = count[i+1] XOR count[i] for i < WIDTH-1; upper bits 0.
REQ-024 MODE 2: code_out SHALL have exactly one bit set, at index count (count=0 sets bit 0); no offset and no all-zero state.
REQ-025 MODE 1: successive enabled counts, wraps included, SHALL change exactly one bit of code_out.
REQ-026 MODE values other than 0..2 SHALL behave as MODE 0.
REQ-027 The design SHALL have no combinational path from any input to any output.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force count=0 and tc=0.
REQ-029 rst_n=0 SHALL force code_out to 0 in MODE 0 and MODE 1, and to 1 (bit 0 set) in MODE 2.
REQ-030 Reset asserted mid-count SHALL discard the current count; after release, counting resumes from 0 on the first enabled edge.

Verification
REQ-031 WIDTH=3, MODE=1, en=1, up_dn=1 from reset, 9 edges: count goes 1,2,...,7,0,1; code_out goes 001,011,010,110,111,101,100,000,001; tc=1 only on the 7->0 edge.
REQ-032 WIDTH=3, MODE=2, load=1, load_val=5 -> count=5, code_out=8'b0010_0000; then down-count 6 edges: count 4,3,2,1,0,7; tc=1 only on the 0->7 edge.
REQ-033 clr=1, load=1 and en=1 on the same edge with count=6 -> count=0, tc=0; load=1 and en=1 with load_val=2 -> count=2, tc=0.
REQ-034 WIDTH=4, MODE=0, count=9, rst_n pulsed low between edges -> count, code_out and tc read 0 before the next edge; the first enabled edge after release gives count=1.
REQ-035 en=0 for 5 edges at count=3, MODE=1 -> count=3, code_out=0010 and tc=0 throughout.
REQ-036 Exhaustive up/down sweep, WIDTH=2..6, all MODEs: code_out matches the REQ-022..024 reference model every cycle; MODE 1 Hamming distance is 1 on every step.
